// File: rtl/pu_or1k_branch_pkg.sv
// Shared types and defaults for the OR1K conditional-branch resolution path.
package pu_or1k_branch_pkg;

    localparam int BRANCH_PC_WIDTH    = 32;
    localparam int BRANCH_QUEUE_DEPTH = 4;

    typedef struct packed {
        logic                       taken;
        logic [BRANCH_PC_WIDTH-1:0] target;
        logic [BRANCH_PC_WIDTH-1:0] fallthrough;
    } branch_entry_t;

endpackage

// File: rtl/pu_or1k_branch_queue.sv
// In-order FIFO with push, pop, single-cycle clear and occupancy count.
module pu_or1k_branch_queue
    import pu_or1k_branch_pkg::*;
#(
    parameter int WIDTH = $bits(branch_entry_t),
    parameter int DEPTH = BRANCH_QUEUE_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign head_data = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Entry storage; contents are only meaningful while counted.
    always_ff @(posedge clk) begin
        if (push_ok_s && !clear && !rst) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; clear overrides any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/pu_or1k_branch_resolution_unit.sv
// Resolves predicted l.bf/l.bnf in order, trains the predictor and redirects
// fetch on a mispredict, discarding younger wrong-path branches.
module pu_or1k_branch_resolution_unit
    import pu_or1k_branch_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = BRANCH_PC_WIDTH,
    parameter int DEPTH                = BRANCH_QUEUE_DEPTH,
    parameter int STAT_WIDTH           = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pred_valid_i,
    input  logic                            pred_taken_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] pred_target_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] pred_fallthrough_i,
    output logic                            pred_ready_o,
    input  logic                            res_valid_i,
    input  logic                            res_op_bf_i,
    input  logic                            res_op_bnf_i,
    input  logic                            res_flag_i,
    input  logic                            flush_i,
    output logic                            mispredict_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o,
    output logic                            upd_valid_o,
    output logic                            upd_taken_o,
    output logic [$clog2(DEPTH):0]          inflight_o,
    output logic                            res_underflow_o,
    output logic [STAT_WIDTH-1:0]           stat_branches_o,
    output logic [STAT_WIDTH-1:0]           stat_mispredicts_o
);

    localparam int OW      = OPTION_OPERAND_WIDTH;
    localparam int ENTRY_W = 1 + 2 * OW;

    logic [ENTRY_W-1:0]    push_entry_s;
    logic [ENTRY_W-1:0]    head_entry_s;
    logic                  head_taken_s;
    logic [OW-1:0]         head_target_s;
    logic [OW-1:0]         head_fallthrough_s;
    logic                  q_full_s;
    logic                  q_empty_s;
    logic                  resolve_s;
    logic                  actual_taken_s;
    logic                  mispredict_s;
    logic                  clear_s;
    logic                  pop_s;
    logic                  mispredict_r;
    logic [OW-1:0]         redirect_pc_r;
    logic                  upd_valid_r;
    logic                  upd_taken_r;
    logic                  underflow_r;
    logic [STAT_WIDTH-1:0] stat_branches_r;
    logic [STAT_WIDTH-1:0] stat_mispredicts_r;

    assign push_entry_s       = {pred_taken_i, pred_target_i, pred_fallthrough_i};
    assign head_taken_s       = head_entry_s[ENTRY_W-1];
    assign head_target_s      = head_entry_s[2*OW-1:OW];
    assign head_fallthrough_s = head_entry_s[OW-1:0];

    // A branch with neither l.bf nor l.bnf decoded falls out as not taken.
    assign actual_taken_s = (res_op_bf_i && res_flag_i) || (res_op_bnf_i && !res_flag_i);
    assign resolve_s      = res_valid_i && !q_empty_s && !flush_i;
    assign mispredict_s   = resolve_s && (actual_taken_s != head_taken_s);
    assign pop_s          = res_valid_i && !flush_i;
    assign clear_s        = flush_i || mispredict_s;

    pu_or1k_branch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear_s),
        .push      (pred_valid_i),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head_data (head_entry_s),
        .full      (q_full_s),
        .empty     (q_empty_s),
        .count     (inflight_o)
    );

    assign pred_ready_o = !q_full_s;

    // Registered resolution results, redirect and saturating statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict_r       <= 1'b0;
            redirect_pc_r      <= {OW{1'b0}};
            upd_valid_r        <= 1'b0;
            upd_taken_r        <= 1'b0;
            underflow_r        <= 1'b0;
            stat_branches_r    <= {STAT_WIDTH{1'b0}};
            stat_mispredicts_r <= {STAT_WIDTH{1'b0}};
        end else begin
            mispredict_r <= mispredict_s;
            upd_valid_r  <= resolve_s;
            upd_taken_r  <= resolve_s && actual_taken_s;
            if (mispredict_s) begin
                redirect_pc_r <= actual_taken_s ? head_target_s : head_fallthrough_s;
            end
            if (res_valid_i && q_empty_s && !flush_i) begin
                underflow_r <= 1'b1;
            end
            if (resolve_s && (stat_branches_r != {STAT_WIDTH{1'b1}})) begin
                stat_branches_r <= stat_branches_r + STAT_WIDTH'(1);
            end
            if (mispredict_s && (stat_mispredicts_r != {STAT_WIDTH{1'b1}})) begin
                stat_mispredicts_r <= stat_mispredicts_r + STAT_WIDTH'(1);
            end
        end
    end

    assign mispredict_o       = mispredict_r;
    assign redirect_pc_o      = redirect_pc_r;
    assign upd_valid_o        = upd_valid_r;
    assign upd_taken_o        = upd_taken_r;
    assign res_underflow_o    = underflow_r;
    assign stat_branches_o    = stat_branches_r;
    assign stat_mispredicts_o = stat_mispredicts_r;

endmodule

// File: tb/tb_pu_or1k_branch_resolution_unit.sv
// Directed bench for pu_or1k_branch_resolution_unit; narrow stat counters
// keep the saturation check short.
module tb_pu_or1k_branch_resolution_unit;

    localparam int OW = 32;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          pred_valid_i, pred_taken_i;
    logic [OW-1:0] pred_target_i, pred_fallthrough_i;
    logic          pred_ready_o;
    logic          res_valid_i, res_op_bf_i, res_op_bnf_i, res_flag_i, flush_i;
    logic          mispredict_o;
    logic [OW-1:0] redirect_pc_o;
    logic          upd_valid_o, upd_taken_o;
    logic [2:0]    inflight_o;
    logic          res_underflow_o;
    logic [SW-1:0] stat_branches_o, stat_mispredicts_o;

    int tests  = 0;
    int failed = 0;

    pu_or1k_branch_resolution_unit #(
        .OPTION_OPERAND_WIDTH (OW),
        .DEPTH                (4),
        .STAT_WIDTH           (SW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .pred_valid_i       (pred_valid_i),
        .pred_taken_i       (pred_taken_i),
        .pred_target_i      (pred_target_i),
        .pred_fallthrough_i (pred_fallthrough_i),
        .pred_ready_o       (pred_ready_o),
        .res_valid_i        (res_valid_i),
        .res_op_bf_i        (res_op_bf_i),
        .res_op_bnf_i       (res_op_bnf_i),
        .res_flag_i         (res_flag_i),
        .flush_i            (flush_i),
        .mispredict_o       (mispredict_o),
        .redirect_pc_o      (redirect_pc_o),
        .upd_valid_o        (upd_valid_o),
        .upd_taken_o        (upd_taken_o),
        .inflight_o         (inflight_o),
        .res_underflow_o    (res_underflow_o),
        .stat_branches_o    (stat_branches_o),
        .stat_mispredicts_o (stat_mispredicts_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pred_valid_i = 1'b0; pred_taken_i = 1'b0;
        pred_target_i = 32'h0; pred_fallthrough_i = 32'h0;
        res_valid_i = 1'b0; res_op_bf_i = 1'b0; res_op_bnf_i = 1'b0;
        res_flag_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic set_push(input logic tk, input logic [31:0] tgt, input logic [31:0] ft);
        pred_valid_i = 1'b1; pred_taken_i = tk;
        pred_target_i = tgt; pred_fallthrough_i = ft;
    endtask

    task automatic set_res(input logic bf, input logic bnf, input logic flag);
        res_valid_i = 1'b1; res_op_bf_i = bf; res_op_bnf_i = bnf; res_flag_i = flag;
    endtask

    task automatic push(input logic tk, input logic [31:0] tgt, input logic [31:0] ft);
        set_push(tk, tgt, ft); tick(); idle_inputs();
    endtask

    task automatic resolve(input logic bf, input logic bnf, input logic flag);
        set_res(bf, bnf, flag); tick(); idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_inflight", 32'(inflight_o), 32'd0);
        chk("rst_ready", 32'(pred_ready_o), 32'd1);
        chk("rst_mispredict", 32'(mispredict_o), 32'd0);
        chk("rst_upd_valid", 32'(upd_valid_o), 32'd0);
        chk("rst_upd_taken", 32'(upd_taken_o), 32'd0);
        chk("rst_underflow", 32'(res_underflow_o), 32'd0);
        chk("rst_redirect", redirect_pc_o, 32'd0);
        chk("rst_stat_br", 32'(stat_branches_o), 32'd0);
        chk("rst_stat_mp", 32'(stat_mispredicts_o), 32'd0);

        // Correct taken prediction
        push(1'b1, 32'h100, 32'h0C);
        chk("t1_inflight", 32'(inflight_o), 32'd1);
        resolve(1'b1, 1'b0, 1'b1);
        chk("t1_upd_valid", 32'(upd_valid_o), 32'd1);
        chk("t1_upd_taken", 32'(upd_taken_o), 32'd1);
        chk("t1_mispredict", 32'(mispredict_o), 32'd0);
        chk("t1_stat_br", 32'(stat_branches_o), 32'd1);
        chk("t1_inflight_after", 32'(inflight_o), 32'd0);
        tick();
        chk("t1_upd_pulse_end", 32'(upd_valid_o), 32'd0);

        // Predicted taken, actually not taken
        push(1'b1, 32'h200, 32'h44);
        resolve(1'b1, 1'b0, 1'b0);
        chk("t2_mispredict", 32'(mispredict_o), 32'd1);
        chk("t2_redirect", redirect_pc_o, 32'h44);
        chk("t2_upd_taken", 32'(upd_taken_o), 32'd0);
        chk("t2_stat_mp", 32'(stat_mispredicts_o), 32'd1);
        chk("t2_stat_br", 32'(stat_branches_o), 32'd2);
        tick();
        chk("t2_pulse_end", 32'(mispredict_o), 32'd0);
        chk("t2_redirect_hold", redirect_pc_o, 32'h44);

        // l.bnf with flag clear is taken; predicted not taken
        push(1'b0, 32'h300, 32'h48);
        resolve(1'b0, 1'b1, 1'b0);
        chk("t2b_mispredict", 32'(mispredict_o), 32'd1);
        chk("t2b_redirect", redirect_pc_o, 32'h300);
        chk("t2b_upd_taken", 32'(upd_taken_o), 32'd1);

        // Mispredict oldest of 3 while a 4th is pushed: everything discarded
        push(1'b0, 32'h310, 32'h50);
        push(1'b0, 32'h320, 32'h54);
        push(1'b0, 32'h330, 32'h58);
        chk("t3_inflight3", 32'(inflight_o), 32'd3);
        set_push(1'b0, 32'h340, 32'h5C);
        set_res(1'b1, 1'b0, 1'b1);
        tick(); idle_inputs();
        chk("t3_inflight0", 32'(inflight_o), 32'd0);
        chk("t3_mispredict", 32'(mispredict_o), 32'd1);
        chk("t3_redirect", redirect_pc_o, 32'h310);
        chk("t3_stat_mp", 32'(stat_mispredicts_o), 32'd3);
        resolve(1'b1, 1'b0, 1'b1);
        chk("t3_underflow", 32'(res_underflow_o), 32'd1);
        chk("t3_no_upd", 32'(upd_valid_o), 32'd0);
        chk("t3_stat_br_same", 32'(stat_branches_o), 32'd4);

        // Fill, drop a push while full, then push+resolve while full
        for (int i = 0; i < 4; i++) begin
            push(1'b0, 32'h400 + 32'(i) * 32'h10, 32'h500 + 32'(i) * 32'h4);
        end
        chk("t4_full_ready", 32'(pred_ready_o), 32'd0);
        chk("t4_inflight4", 32'(inflight_o), 32'd4);
        push(1'b1, 32'h4F0, 32'h5F0);
        chk("t4_drop_inflight", 32'(inflight_o), 32'd4);
        set_push(1'b1, 32'h4E0, 32'h5E0);
        set_res(1'b1, 1'b0, 1'b0);
        tick(); idle_inputs();
        chk("t4_inflight3", 32'(inflight_o), 32'd3);
        chk("t4_upd_valid", 32'(upd_valid_o), 32'd1);
        chk("t4_no_mispredict", 32'(mispredict_o), 32'd0);
        chk("t4_ready_again", 32'(pred_ready_o), 32'd1);
        resolve(1'b1, 1'b0, 1'b0);
        resolve(1'b1, 1'b0, 1'b0);
        resolve(1'b0, 1'b1, 1'b0);
        chk("t4_last_redirect", redirect_pc_o, 32'h430);
        chk("t4_last_mispredict", 32'(mispredict_o), 32'd1);
        chk("t4_stat_br", 32'(stat_branches_o), 32'd8);
        chk("t4_stat_mp", 32'(stat_mispredicts_o), 32'd4);
        chk("t4_empty", 32'(inflight_o), 32'd0);
        resolve(1'b1, 1'b0, 1'b0);
        chk("t4_lost_entry_no_upd", 32'(upd_valid_o), 32'd0);
        chk("t4_stat_br_hold", 32'(stat_branches_o), 32'd8);

        // Flush with a same-cycle resolve and push
        push(1'b1, 32'h600, 32'h60);
        push(1'b0, 32'h610, 32'h64);
        set_push(1'b0, 32'h620, 32'h68);
        set_res(1'b1, 1'b0, 1'b1);
        flush_i = 1'b1;
        tick(); idle_inputs();
        chk("t5_inflight", 32'(inflight_o), 32'd0);
        chk("t5_upd_valid", 32'(upd_valid_o), 32'd0);
        chk("t5_mispredict", 32'(mispredict_o), 32'd0);
        chk("t5_stat_br", 32'(stat_branches_o), 32'd8);

        // Saturation of both statistics counters
        for (int i = 0; i < 11; i++) begin
            push(1'b0, 32'h700, 32'h70);
            resolve(1'b1, 1'b0, 1'b1);
        end
        chk("t6_stat_mp_max", 32'(stat_mispredicts_o), 32'hF);
        push(1'b0, 32'h710, 32'h74);
        resolve(1'b1, 1'b0, 1'b1);
        chk("t6_mispredict", 32'(mispredict_o), 32'd1);
        chk("t6_stat_mp_sat", 32'(stat_mispredicts_o), 32'hF);
        chk("t6_stat_br_sat", 32'(stat_branches_o), 32'hF);

        // Reset mid-operation with a resolve pending
        push(1'b1, 32'h800, 32'h80);
        push(1'b0, 32'h810, 32'h84);
        set_res(1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        tick(); idle_inputs();
        rst = 1'b0;
        chk("t7_inflight", 32'(inflight_o), 32'd0);
        chk("t7_mispredict", 32'(mispredict_o), 32'd0);
        chk("t7_upd_valid", 32'(upd_valid_o), 32'd0);
        chk("t7_stat_mp", 32'(stat_mispredicts_o), 32'd0);
        chk("t7_underflow", 32'(res_underflow_o), 32'd0);
        chk("t7_redirect", redirect_pc_o, 32'd0);
        tick();
        chk("t7_no_late_pulse", 32'(mispredict_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pu_or1k_branch_resolution_unit.md
Name: pu_or1k_branch_resolution_unit

Overview:
- Resolver end of the conditional-branch prediction interface.
- The decode stage pushes each predicted l.bf/l.bnf, with its prediction and both candidate PCs, into an in-order in-flight queue.
- When execute resolves the oldest branch, the unit compares the actual outcome with the prediction and does four things:
  - emits the training update back to the saturation-counter predictor;
  - raises a one-cycle mispredict pulse;
  - drives the correct redirect PC;
  - discards all younger wrong-path entries.
- Sits between decode/execute and the fetch redirect logic.

Parameters:
- OPTION_OPERAND_WIDTH, 32, PC width.
- DEPTH, 4, in-flight branch queue entries; power of two, minimum 2.
- STAT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- pred_valid_i  in  1  decode pushes a conditional branch this cycle
- pred_taken_i  in  1  predictor's taken decision for the pushed branch
- pred_target_i  in  OPTION_OPERAND_WIDTH  branch target PC
- pred_fallthrough_i  in  OPTION_OPERAND_WIDTH  fall-through PC
- pred_ready_o  out  1  queue not full
- res_valid_i  in  1  execute resolves the oldest in-flight branch
- res_op_bf_i  in  1  resolved instruction is l.bf
- res_op_bnf_i  in  1  resolved instruction is l.bnf
- res_flag_i  in  1  SR[F] at resolution
- flush_i  in  1  exception/pipeline flush
- mispredict_o  out  1  one-cycle mispredict pulse
- redirect_pc_o  out  OPTION_OPERAND_WIDTH  correct PC, valid while mispredict_o=1
- upd_valid_o  out  1  predictor training strobe
- upd_taken_o  out  1  actual outcome for predictor training
- inflight_o  out  $clog2(DEPTH)+1  current queue occupancy
- res_underflow_o  out  1  sticky: res_valid_i seen while queue empty
- stat_branches_o  out  STAT_WIDTH  resolved branch count
- stat_mispredicts_o  out  STAT_WIDTH  mispredict count

Behaviour:
- Reset and clock: reset rst, synchronous, active-high; clock clk.
- Reset values:
  - queue empty, inflight_o=0, pred_ready_o=1;
  - mispredict_o, upd_valid_o, upd_taken_o, res_underflow_o = 0;
  - redirect_pc_o=0; both stat counters 0.
- Reset asserted mid-operation discards all entries; no pulse is produced for any branch in flight.
- Push:
  - Accepted when pred_valid_i && pred_ready_o.
  - Entry = {pred_taken, target, fallthrough}.
  - pred_ready_o = (inflight_o != DEPTH), a combinational function of registered occupancy.
  - A push while full is dropped; upstream must stall.
- Resolve (res_valid_i with queue non-empty):
  - Pop the head entry.
  - actual_taken = (res_op_bf_i && res_flag_i) || (res_op_bnf_i && !res_flag_i).
  - If res_op_bf_i and res_op_bnf_i are both 0, treat the branch as not taken.
- Resolve is registered, with 1-cycle latency. On the next cycle:
  - upd_valid_o=1 and upd_taken_o=actual_taken, for one cycle;
  - stat_branches_o increments.
- Mispredict (actual_taken != head.pred_taken):
  - Next cycle: mispredict_o=1 for one cycle.
  - redirect_pc_o = actual_taken ? head.target : head.fallthrough.
  - stat_mispredicts_o increments.
  - At the same edge the whole queue is cleared; inflight_o=0 next cycle.
  - A push in the same cycle is wrong-path and is discarded.
- Correct prediction: no mispredict pulse; redirect_pc_o holds its last value.
- Simultaneous push and correct resolve: both take effect and occupancy is unchanged.
  - A push while full is not accepted, even alongside a resolve.
- Resolve while empty:
  - Ignored: no update, no pulse, no stat change.
  - res_underflow_o sets to 1 and stays set until rst.
- flush_i has top priority:
  - Clears the queue.
  - Cancels any same-cycle push and resolve, so no upd/mispredict/stat effect next cycle.
  - Outputs registered from earlier cycles still complete.
- Stat counters saturate at all-ones and do not wrap.
- Queue pointers are DEPTH-modulo and wrap naturally; occupancy is tracked separately so that full and empty are distinct.

Decomposition:
- Shared package pu_or1k_branch_pkg holds:
  - branch_entry_t, a packed struct {taken, target, fallthrough} with widths from OPTION_OPERAND_WIDTH;
  - the BRANCH_QUEUE_DEPTH default constant.
- One sub-module, pu_or1k_branch_queue: synchronous in-order FIFO with push, pop, single-cycle clear, full/empty flags and count.
  - It is reusable by future return-address and loop-buffer logic.
- Comparison, update and stats logic lives in the top module.

Test Plan:
- Push {taken=1, tgt=0x100, ft=0x0C}, then resolve bf with flag=1 → next cycle upd_valid_o=1, upd_taken_o=1, mispredict_o=0, stat_branches_o=1.
- Push {taken=1, tgt=0x200, ft=0x44}, then resolve bf with flag=0 → next cycle mispredict_o=1, redirect_pc_o=0x44, upd_taken_o=0, stat_mispredicts_o=1.
- Push 3 entries, mispredict the oldest while pushing a 4th in the same cycle → inflight_o=0 next cycle, and the following resolve sets res_underflow_o=1.
- Push DEPTH=4 entries → pred_ready_o=0 and a 5th push is dropped; then push and resolve in the same cycle → inflight_o=3, and the pushed entry is lost.
- Push 2 entries, then flush_i together with res_valid_i → inflight_o=0, and upd_valid_o=0, mispredict_o=0 next cycle.
- Force stat_mispredicts_o to 0xFFFF, then cause one more mispredict → the counter stays at 0xFFFF.
